cfg_out_sel_ctx_seq: RTL and testbench

//  Double-buffered, context-sequenced table of PEA output-crossbar selectors.

---
 rtl/cfg_out_sel_ctx_seq_pkg.sv | 17 +
 rtl/cfg_out_sel_ctx_seq_ctx_counter.sv | 56 +++++
 rtl/cfg_out_sel_ctx_seq.sv | 150 +++++++++++++++
 tb/tb_cfg_out_sel_ctx_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_out_sel_ctx_seq_pkg.sv
// Shared defaults and types for the PEA output-selector context sequencer.
package cfg_out_sel_ctx_seq_pkg;

    localparam int unsigned N         = 4;
    localparam int unsigned N_OUT_DEF = 2;
    localparam int unsigned LOG_M     = 3;
    localparam int unsigned KMEM_SIZE = 8;

    typedef logic [LOG_M-1:0] sel_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRunCp
    } ctx_seq_state_e;

endpackage

// File: rtl/cfg_out_sel_ctx_seq_ctx_counter.sv
// Context index counter: steps toward a clamped last context, wraps to 0 and
// pulses wrap_o in the cycle the wrapped index becomes visible.
module cfg_out_sel_ctx_seq_ctx_counter #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CTX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [CTX_W-1:0] last_i,
    output logic             at_last_o,
    output logic [CTX_W-1:0] ctx_o,
    output logic [CTX_W-1:0] ctx_nxt_o,
    output logic             wrap_o
);

    localparam logic [CTX_W-1:0] MAX_CTX = CTX_W'(DEPTH - 1);

    logic [CTX_W-1:0] ctx_q, ctx_d;
    logic [CTX_W-1:0] last_eff;
    logic             wrap_q, wrap_d;

    always_comb begin
        last_eff  = (last_i > MAX_CTX) ? MAX_CTX : last_i;
        // Top-of-table also wraps so a shrinking last_i can never run off the end
        at_last_o = (ctx_q == last_eff) || (ctx_q == MAX_CTX);
        ctx_d     = ctx_q;
        wrap_d    = 1'b0;
        if (clr_i) begin
            ctx_d = '0;
        end else if (step_i) begin
            if (at_last_o) begin
                ctx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ctx_d = ctx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ctx_q  <= ctx_d;
            wrap_q <= wrap_d;
        end
    end

    assign ctx_o     = ctx_q;
    assign ctx_nxt_o = ctx_d;
    assign wrap_o    = wrap_q;

endmodule

// File: rtl/cfg_out_sel_ctx_seq.sv
// Double-buffered, context-sequenced PEA output-crossbar selector table.
// Optional write parity check enabled by defining CFG_OUT_SEL_PARITY_EN.
module cfg_out_sel_ctx_seq
    import cfg_out_sel_ctx_seq_pkg::*;
#(
    parameter int unsigned N_PE  = N,
    parameter int unsigned N_OUT = N_OUT_DEF,
    parameter int unsigned DEPTH = KMEM_SIZE,
    parameter int unsigned SEL_W = LOG_M,
    localparam int unsigned CTX_W = $clog2(DEPTH),
    localparam int unsigned PE_W  = $clog2(N_PE),
    localparam int unsigned OUT_W = $clog2(N_OUT),
    localparam int unsigned VEC_W = N_PE * N_OUT * SEL_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [PE_W-1:0]  wr_pe_i,
    input  logic [OUT_W-1:0] wr_out_i,
    input  logic [CTX_W-1:0] wr_ctx_i,
    input  logic [SEL_W-1:0] wr_sel_i,
    input  logic             commit_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic [CTX_W-1:0] last_ctx_i,
    output logic [CTX_W-1:0] ctx_o,
    output logic [VEC_W-1:0] sel_output_o,
    output logic             sel_valid_o,
    output logic             wrap_o,
    output logic             busy_o
`ifdef CFG_OUT_SEL_PARITY_EN
    ,
    input  logic             wr_par_i,
    output logic             par_err_o
`endif
);

    ctx_seq_state_e   state_q, state_d;
    logic             active_q, active_d;
    logic [VEC_W-1:0] bank_q [2][DEPTH];
    logic [VEC_W-1:0] sel_q;
    logic [CTX_W-1:0] ctx_nxt;
    logic             swap, clr, step_en, at_last;
    logic             wr_fire, wr_keep;

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i)  state_d = StRun;
                if (commit_i) swap = 1'b1;
            end
            StRun: begin
                if (stop_i)        state_d = StIdle;
                else if (commit_i) state_d = StRunCp;
            end
            StRunCp: begin
                // Pending commit is honoured on abort as well as at the loop boundary
                if (stop_i) begin
                    state_d = StIdle;
                    swap    = 1'b1;
                end else if (step_i && at_last) begin
                    state_d = StRun;
                    swap    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign clr        = stop_i && (state_q != StIdle);
    assign step_en    = step_i && !stop_i && (state_q != StIdle);
    assign active_d   = active_q ^ swap;
    assign wr_ready_o = !((state_q == StRunCp) || swap);
    assign wr_fire    = wr_valid_i && wr_ready_o;

`ifdef CFG_OUT_SEL_PARITY_EN
    logic par_ok;
    logic par_err_q;

    assign par_ok  = ((^wr_sel_i) == wr_par_i);
    assign wr_keep = wr_fire && par_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i)                  par_err_q <= 1'b0;
        else if (wr_fire && !par_ok) par_err_q <= 1'b1;
    end

    assign par_err_o = par_err_q;
`else
    assign wr_keep = wr_fire;
`endif

    cfg_out_sel_ctx_seq_ctx_counter #(
        .DEPTH (DEPTH)
    ) u_ctx_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr),
        .step_i    (step_en),
        .last_i    (last_ctx_i),
        .at_last_o (at_last),
        .ctx_o     (ctx_o),
        .ctx_nxt_o (ctx_nxt),
        .wrap_o    (wrap_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            // Writes never hit bank active_d this cycle, so pre-write contents are exact
            sel_q    <= bank_q[active_d][ctx_nxt];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < int'(DEPTH); c++) begin
                    bank_q[b][c] <= '0;
                end
            end
        end else if (wr_keep) begin
            for (int c = 0; c < int'(DEPTH); c++) begin
                for (int p = 0; p < int'(N_PE); p++) begin
                    for (int o = 0; o < int'(N_OUT); o++) begin
                        if (wr_ctx_i == CTX_W'(c) && wr_pe_i == PE_W'(p) &&
                            wr_out_i == OUT_W'(o)) begin
                            bank_q[!active_q][c][(p*int'(N_OUT)+o)*int'(SEL_W) +: SEL_W]
                                <= wr_sel_i;
                        end
                    end
                end
            end
        end
    end

    assign sel_output_o = sel_q;
    assign sel_valid_o  = (state_q != StIdle);
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_cfg_out_sel_ctx_seq.sv
// Directed self-checking bench for cfg_out_sel_ctx_seq (default parameters).
module tb_cfg_out_sel_ctx_seq;

    localparam int N_PE  = 4;
    localparam int N_OUT = 2;
    localparam int SEL_W = 3;
    localparam int CTX_W = 3;
    localparam int VW    = N_PE * N_OUT * SEL_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_pe;
    logic             wr_out;
    logic [CTX_W-1:0] wr_ctx;
    logic [SEL_W-1:0] wr_sel;
    logic             commit, start, stop, step;
    logic [CTX_W-1:0] last_ctx;
    logic [CTX_W-1:0] ctx;
    logic [VW-1:0]    sel_out;
    logic             sel_valid, wrap, busy;
`ifdef CFG_OUT_SEL_PARITY_EN
    logic             wr_par;
    logic             par_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cfg_out_sel_ctx_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_pe_i      (wr_pe),
        .wr_out_i     (wr_out),
        .wr_ctx_i     (wr_ctx),
        .wr_sel_i     (wr_sel),
        .commit_i     (commit),
        .start_i      (start),
        .stop_i       (stop),
        .step_i       (step),
        .last_ctx_i   (last_ctx),
        .ctx_o        (ctx),
        .sel_output_o (sel_out),
        .sel_valid_o  (sel_valid),
        .wrap_o       (wrap),
        .busy_o       (busy)
`ifdef CFG_OUT_SEL_PARITY_EN
        ,
        .wr_par_i     (wr_par),
        .par_err_o    (par_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected selector vector: field [pe][out] = (pe + out + ctx + k) mod 8
    function automatic logic [VW-1:0] tbl(input int c, input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int p = 0; p < N_PE; p++)
            for (int o = 0; o < N_OUT; o++)
                v[(p*N_OUT+o)*SEL_W +: SEL_W] = SEL_W'((p + o + c + k) % 8);
        return v;
    endfunction

    task automatic wr(input int c, input int p, input int o, input int s);
        wr_valid = 1'b1;
        wr_ctx   = CTX_W'(c);
        wr_pe    = 2'(p);
        wr_out   = 1'(o);
        wr_sel   = SEL_W'(s);
`ifdef CFG_OUT_SEL_PARITY_EN
        wr_par   = ^wr_sel;
`endif
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wr_tbl(input int k);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < N_PE; p++)
                for (int o = 0; o < N_OUT; o++)
                    wr(c, p, o, (p + o + c + k) % 8);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_pe = '0; wr_out = 1'b0; wr_ctx = '0; wr_sel = '0;
        commit = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; last_ctx = 3'd3;
`ifdef CFG_OUT_SEL_PARITY_EN
        wr_par = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ctx", 32'(ctx), 32'd0);
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sel_valid), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);

        // Fill shadow bank, then commit from IDLE
        wr_tbl(0);
        chk("shadow_hidden", 32'(sel_out), 32'd0);
        commit = 1'b1;
        #1;
        chk("ready_swap_idle", 32'(wr_ready), 32'd0);
        tick();
        commit = 1'b0;
        chk("idle_commit_sel", 32'(sel_out), 32'(tbl(0, 0)));
        chk("idle_commit_busy", 32'(busy), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(sel_valid), 32'd1);
        chk("start_ctx", 32'(ctx), 32'd0);

        step = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_ctx", 32'(ctx), 32'(i % 4));
            chk("seq_wrap", 32'(wrap), (i == 4) ? 32'd1 : 32'd0);
            chk("seq_sel", 32'(sel_out), 32'(tbl(i % 4, 0)));
        end
        step = 1'b0;
        tick();
        chk("wrap_pulse_end", 32'(wrap), 32'd0);

        // Rewrite shadow while running; commit at ctx1 holds until the wrap
        wr_tbl(4);
        chk("run_active_kept", 32'(sel_out), 32'(tbl(0, 0)));
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("cp_ctx1", 32'(ctx), 32'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cp_ready_low", 32'(wr_ready), 32'd0);
        step = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk("cp_ctx", 32'(ctx), 32'(i));
            chk("cp_ready", 32'(wr_ready), 32'd0);
            chk("cp_old_bank", 32'(sel_out), 32'(tbl(i, 0)));
        end
        tick();
        chk("cp_wrap_ctx", 32'(ctx), 32'd0);
        chk("cp_wrap", 32'(wrap), 32'd1);
        chk("cp_new_bank", 32'(sel_out), 32'(tbl(0, 4)));
        chk("cp_ready_back", 32'(wr_ready), 32'd1);
        chk("cp_busy", 32'(busy), 32'd1);

        // Out-of-range last context clamps to DEPTH-1
        last_ctx = CTX_W'(15);
        for (int i = 0; i < 7; i++) tick();
        chk("clamp_ctx7", 32'(ctx), 32'd7);
        chk("clamp_sel7", 32'(sel_out), 32'd0);
        chk("clamp_nowrap", 32'(wrap), 32'd0);
        tick();
        chk("clamp_wrap_ctx", 32'(ctx), 32'd0);
        chk("clamp_wrap", 32'(wrap), 32'd1);
        chk("clamp_sel0", 32'(sel_out), 32'(tbl(0, 4)));
        step = 1'b0;

        // Stop with step in RUN_CP: back to IDLE at ctx0 with banks swapped
        last_ctx = 3'd3;
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        chk("stop_pre_ctx", 32'(ctx), 32'd2);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        stop = 1'b1;
        step = 1'b1;
        tick();
        stop = 1'b0;
        step = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_valid", 32'(sel_valid), 32'd0);
        chk("stop_ctx", 32'(ctx), 32'd0);
        chk("stop_wrap", 32'(wrap), 32'd0);
        chk("stop_swapped", 32'(sel_out), 32'(tbl(0, 0)));
        chk("stop_ready", 32'(wr_ready), 32'd1);

        // Reset in the middle of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        last_ctx = 3'd7;
        step = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_ctx5", 32'(ctx), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step = 1'b0;
        chk("mrst_ctx", 32'(ctx), 32'd0);
        chk("mrst_sel", 32'(sel_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(sel_valid), 32'd0);
        chk("mrst_wrap", 32'(wrap), 32'd0);
        chk("mrst_ready", 32'(wr_ready), 32'd1);

        // Same-entry writes: last accepted wins
        wr(0, 1, 1, 5);
        wr(0, 1, 1, 2);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("last_wins", 32'(sel_out), 32'h0000_0400);

`ifdef CFG_OUT_SEL_PARITY_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("par_rst", 32'(par_err), 32'd0);
        wr_valid = 1'b1;
        wr_ctx = '0;
        wr_pe = '0;
        wr_out = 1'b0;
        wr_sel = 3'd3;
        wr_par = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("par_err_set", 32'(par_err), 32'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("par_discard", 32'(sel_out), 32'd0);
        chk("par_sticky", 32'(par_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("par_clear", 32'(par_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
